// File: rtl/load_store_unit.sv
// Memory-access stage: forms base+offset effective address, runs a req/ready
// handshake with data memory and writes load results back to the register file.
module load_store_unit #(
    parameter int DATA_W   = 64,
    parameter int OFF_W    = 12,
    parameter int TIMEOUT  = 15,
    parameter int ZERO_REG = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_store,
    input  logic [DATA_W-1:0] base,
    input  logic [DATA_W-1:0] store_data,
    input  logic [OFF_W-1:0]  offset,
    input  logic [4:0]        rd,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              rf_writeenable,
    output logic [4:0]        rf_writeto,
    output logic [DATA_W-1:0] rf_writedat,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, REQ, WB, FIN, ERR} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              is_store_q, is_store_d;
    logic [4:0]        rd_q, rd_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic              rf_we_q, rf_we_d;
    logic [4:0]        rf_writeto_q, rf_writeto_d;
    logic [DATA_W-1:0] rf_writedat_q, rf_writedat_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] eff_addr;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        is_store_d    = is_store_q;
        rd_d          = rd_q;
        rf_writeto_d  = rf_writeto_q;
        rf_writedat_d = rf_writedat_q;
        eff_addr      = base + {{(DATA_W-OFF_W){offset[OFF_W-1]}}, offset};

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start) begin
                    addr_d     = eff_addr;
                    wdata_d    = store_data;
                    is_store_d = is_store;
                    rd_d       = rd;
                    state_d    = (eff_addr[2:0] != 3'd0) ? ERR : REQ;
                end
            end
            REQ: begin
                if (mem_ready) begin
                    if (is_store_q) begin
                        state_d = FIN;
                    end else begin
                        state_d       = WB;
                        rf_writedat_d = mem_rdata;
                        rf_writeto_d  = rd_q;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CNT_W'(TIMEOUT)) state_d = ERR;
                end
            end
            WB, FIN, ERR: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they are registered
        // yet line up with the state they belong to.
        mem_req_d = (state_d == REQ);
        mem_we_d  = (state_d == REQ) && is_store_d;
        rf_we_d   = (state_d == WB) && (rd_d != 5'(ZERO_REG));
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == WB) || (state_d == FIN) || (state_d == ERR);
        err_d     = (state_d == ERR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            is_store_q    <= 1'b0;
            rd_q          <= '0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            rf_we_q       <= 1'b0;
            rf_writeto_q  <= '0;
            rf_writedat_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            is_store_q    <= is_store_d;
            rd_q          <= rd_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            rf_we_q       <= rf_we_d;
            rf_writeto_q  <= rf_writeto_d;
            rf_writedat_q <= rf_writedat_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    assign mem_req        = mem_req_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = addr_q;
    assign mem_wdata      = wdata_q;
    assign rf_writeenable = rf_we_q;
    assign rf_writeto     = rf_writeto_q;
    assign rf_writedat    = rf_writedat_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;

endmodule
